// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and sequencer state encoding shared with the ALU
package alu_pkg;

  localparam logic [1:0] OP_NOR  = 2'd0;
  localparam logic [1:0] OP_NAND = 2'd1;
  localparam logic [1:0] OP_ADD  = 2'd2;
  localparam logic [1:0] OP_SUB  = 2'd3;

  localparam int FLG_P = 0;
  localparam int FLG_N = 1;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 3;
  localparam int FLG_V = 4;

  typedef enum logic [3:0] {
    S_RX_OP,
    S_RX_A,
    S_RX_B,
    S_LD_A,
    S_LD_B,
    S_LD_OP,
    S_UPD,
    S_CAP,
    S_TX
  } state_t;

endpackage

// File: rtl/byte_shift_reg.sv
// byte_shift_reg: byte-wide LSB-first shift register with parallel load
module byte_shift_reg #(
  parameter int W  = 16,
  parameter int OW = W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [W-1:0]  load_val,
  input  logic          shift,
  input  logic [7:0]    din,
  output logic [OW-1:0] dout
);

  logic [W-1:0] q;

  // new bytes enter at the top so the first byte received ends up in the low byte
  always_ff @(posedge clk)
    if (!rst_n) q <= '0;
    else if (load) q <= load_val;
    else if (shift) q <= W'({din, q} >> 8);

  assign dout = q[OW-1:0];

endmodule

// File: rtl/alu_byte_sequencer.sv
// alu_byte_sequencer: byte-framed command front end that drives the ALU load/update strobes
module alu_byte_sequencer
  import alu_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] alu_data,
  output logic         alu_load_a,
  output logic         alu_load_b,
  output logic         alu_load_op,
  output logic         alu_update,
  input  logic [N-1:0] alu_result,
  input  logic [4:0]   alu_flags,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         err
);

  localparam int BYTES = N / 8;
  localparam int CW    = $clog2(BYTES + 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    op;
  logic [N-1:0]  a, b;
  logic          in_fire, out_fire, op_ok;

  assign in_ready    = state == S_RX_OP || state == S_RX_A || state == S_RX_B;
  assign out_valid   = state == S_TX;
  assign busy        = state != S_RX_OP;
  assign alu_load_a  = state == S_LD_A;
  assign alu_load_b  = state == S_LD_B;
  assign alu_load_op = state == S_LD_OP;
  assign alu_update  = state == S_UPD;
  assign alu_data    = alu_load_a ? a : alu_load_b ? b : alu_load_op ? N'(op) : '0;
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready;
  assign op_ok       = in_data[7:2] == '0;

  // state, byte counter, accepted opcode and the reject pulse
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= S_RX_OP;
      cnt   <= '0;
      op    <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      err   <= in_fire && state == S_RX_OP && !op_ok;
      if (in_fire && state == S_RX_OP && op_ok) op <= in_data[1:0];
    end

  // next state; the counter restarts on every state change and counts transfers otherwise
  always_comb begin
    state_nx = state;
    case (state)
      S_RX_OP: state_nx = in_valid && op_ok ? S_RX_A : S_RX_OP;
      S_RX_A:  state_nx = in_valid && cnt == CW'(BYTES - 1) ? S_RX_B : S_RX_A;
      S_RX_B:  state_nx = in_valid && cnt == CW'(BYTES - 1) ? S_LD_A : S_RX_B;
      S_LD_A:  state_nx = S_LD_B;
      S_LD_B:  state_nx = S_LD_OP;
      S_LD_OP: state_nx = S_UPD;
      S_UPD:   state_nx = S_CAP;
      S_CAP:   state_nx = S_TX;
      S_TX:    state_nx = out_ready && cnt == CW'(BYTES) ? S_RX_OP : S_TX;
      default: state_nx = S_RX_OP;
    endcase
    cnt_nx = state_nx != state ? '0 : cnt + CW'(in_fire | out_fire);
  end

  byte_shift_reg #(.W(N)) u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (1'b0),
    .load_val ('0),
    .shift    (in_fire && state == S_RX_A),
    .din      (in_data),
    .dout     (a)
  );

  byte_shift_reg #(.W(N)) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (1'b0),
    .load_val ('0),
    .shift    (in_fire && state == S_RX_B),
    .din      (in_data),
    .dout     (b)
  );

  byte_shift_reg #(.W(N + 8), .OW(8)) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == S_CAP),
    .load_val ({3'b000, alu_flags, alu_result}),
    .shift    (out_fire),
    .din      (8'h00),
    .dout     (out_data)
  );

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// tb_alu_byte_sequencer: randomized frames against a behavioural ALU/response model
module tb_alu_byte_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alu_data;
  logic        alu_load_a, alu_load_b, alu_load_op, alu_update;
  logic [15:0] alu_result = '0;
  logic [4:0]  alu_flags = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        err;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          err_cnt = 0;
  int          lat;
  logic [7:0]  got [3];
  logic [19:0] slog [$];
  logic [15:0] ra = '0, rb = '0;
  logic [1:0]  rop = '0;

  alu_byte_sequencer #(.N(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_data    (alu_data),
    .alu_load_a  (alu_load_a),
    .alu_load_b  (alu_load_b),
    .alu_load_op (alu_load_op),
    .alu_update  (alu_update),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got_v, exp_v);
    end
  endtask

  // {V,C,Z,N,P, result} from plain arithmetic
  function automatic logic [20:0] alu_ref(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'd0: s = {1'b0, ~(a | b)};
      2'd1: s = {1'b0, ~(a & b)};
      2'd2: begin
        s = {1'b0, a} + {1'b0, b};
        c = s[16];
        v = (a[15] == b[15]) && (s[15] != a[15]);
      end
      default: begin
        s = {1'b0, a} - {1'b0, b};
        c = s[16];
        v = (a[15] != b[15]) && (s[15] != a[15]);
      end
    endcase
    return {v, c, s[15:0] == 16'h0, s[15], ~^s[15:0], s[15:0]};
  endfunction

  // environment ALU: registers operands on loads, result/flags on update
  always @(posedge clk) begin
    logic [20:0] r;
    if (alu_load_a) ra <= alu_data;
    if (alu_load_b) rb <= alu_data;
    if (alu_load_op) rop <= alu_data[1:0];
    if (alu_update) begin
      r = alu_ref(rop, ra, rb);
      alu_result <= r[15:0];
      alu_flags  <= r[20:16];
    end
  end

  // strobe/err monitor sampled mid-cycle
  always @(negedge clk) begin
    logic [3:0] s;
    s = {alu_load_a, alu_load_b, alu_load_op, alu_update};
    if (s != 4'b0) slog.push_back({s, alu_data});
    if ($countones(s) > 1) check("strobe_onehot", 32'(s), 32'(s & -s));
    if (s == 4'b0 && alu_data != 16'h0) check("idle_alu_data", 32'(alu_data), 0);
    if (err) err_cnt++;
  end

  task automatic send_byte(input logic [7:0] v);
    int k;
    in_data  = v;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("in_ready_wait", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] opb, input logic [15:0] a, input logic [15:0] b);
    send_byte(opb);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(b[7:0]);
    send_byte(b[15:8]);
  endtask

  task automatic recv(input int hold, input logic [7:0] first, input bit bp);
    int k, n;
    k = 0;
    in_valid = 1'b1;
    in_data  = 8'h00;
    while (!out_valid && k < 50) begin
      check("rdy_low_exec", 32'(in_ready), 0);
      @(posedge clk); #1;
      k++;
    end
    lat = k;
    check("out_valid_wait", 32'(out_valid), 1);
    check("busy_tx", 32'(busy), 1);
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(out_valid), 1);
      check("hold_data", 32'(out_data), 32'(first));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n = 0;
    k = 0;
    while (n < 3 && k < 100) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        got[n] = out_data;
        n++;
      end
      @(posedge clk); #1;
      k++;
    end
    out_ready = 1'b0;
    check("tx_count", 32'(n), 3);
    check("tx_done_ready", 32'(in_ready), 1);
    check("tx_done_valid", 32'(out_valid), 0);
  endtask

  task automatic run_frame(input logic [7:0] opb, input logic [15:0] a, input logic [15:0] b,
                           input int hold, input bit bp);
    logic [20:0] r;
    r = alu_ref(opb[1:0], a, b);
    slog.delete();
    send_frame(opb, a, b);
    recv(hold, r[7:0], bp);
    check("latency", 32'(lat), 5);
    check("res_lo", 32'(got[0]), 32'(r[7:0]));
    check("res_hi", 32'(got[1]), 32'(r[15:8]));
    check("flags", 32'(got[2]), 32'({3'b000, r[20:16]}));
    check("strobe_cnt", 32'(slog.size()), 4);
    if (slog.size() == 4) begin
      check("ld_a", 32'(slog[0]), 32'({4'b1000, a}));
      check("ld_b", 32'(slog[1]), 32'({4'b0100, b}));
      check("ld_op", 32'(slog[2]), 32'({4'b0010, 14'h0, opb[1:0]}));
      check("upd", 32'(slog[3]), 32'({4'b0001, 16'h0}));
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_data"}, 32'(out_data), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_strobes"}, 32'({alu_load_a, alu_load_b, alu_load_op, alu_update}), 0);
    check({tag, "_alu_data"}, 32'(alu_data), 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  opb;
    logic [15:0] a, b;
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(8'h02, 16'h1234, 16'h0F0F, 0, 1'b0);
    check("t1_b0", 32'(got[0]), 32'h43);
    check("t1_b1", 32'(got[1]), 32'h21);
    check("t1_b2", 32'(got[2]), 32'h00);
    run_frame(8'h03, 16'h0005, 16'h0005, 0, 1'b0);
    check("t2_flags", 32'(got[2]), 32'h05);
    run_frame(8'h02, 16'hFFFF, 16'h0001, 0, 1'b0);
    check("t3_flags", 32'(got[2]), 32'h0D);
    run_frame(8'h03, 16'h0000, 16'h0001, 0, 1'b0);
    check("t4_res", 32'({got[1], got[0]}), 32'hFFFF);
    check("t4_flags", 32'(got[2]), 32'h0B);

    slog.delete();
    err_cnt = 0;
    send_byte(8'h84);
    check("err_pulse", 32'(err), 1);
    check("err_in_ready", 32'(in_ready), 1);
    check("err_busy", 32'(busy), 0);
    @(posedge clk); #1;
    check("err_cleared", 32'(err), 0);
    check("err_count", 32'(err_cnt), 1);
    check("err_no_strobe", 32'(slog.size()), 0);
    run_frame(8'h01, 16'hA5A5, 16'h0FF0, 0, 1'b0);

    run_frame(8'h02, 16'h1234, 16'h0F0F, 5, 1'b0);

    slog.delete();
    send_byte(8'h02);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h0F);
    pulse_reset();
    check_idle("rst_rxb");
    repeat (3) @(posedge clk);
    #1;
    check("rst_rxb_no_strobe", 32'(slog.size()), 0);
    run_frame(8'h00, 16'h00F0, 16'h0F00, 0, 1'b0);

    send_frame(8'h02, 16'h1111, 16'h2222);
    for (int k = 0; k < 20 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    check("rst_tx_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    pulse_reset();
    check_idle("rst_tx");
    run_frame(8'h03, 16'h8000, 16'h0001, 0, 1'b1);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        err_cnt = 0;
        send_byte({6'($urandom_range(1, 63)), 2'($urandom)});
        check("rand_err_pulse", 32'(err), 1);
        @(posedge clk); #1;
        check("rand_err_count", 32'(err_cnt), 1);
      end
      opb = {6'h00, 2'($urandom)};
      a   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      run_frame(opb, a, b, 0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
